// File: rtl/param_codeblock.sv
// Parameterised load/branch/write program sequencer with stutter hold.
// Public and secret result words are driven from a small step FSM.
module param_codeblock #(
  parameter int WIDTH       = 4,
  parameter int NUM_SECRETS = 2,
  parameter int LOOP_COUNT  = 3,
  parameter int BRANCH_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stutter_in,
  input  logic [NUM_SECRETS*WIDTH-1:0] secret_in,
  input  logic [WIDTH-1:0]             public_in,
  output logic [WIDTH-1:0]             public_out,
  output logic [WIDTH-1:0]             secret_out,
  output logic                         stutter,
  output logic [2:0]                   pc,
  output logic                         done
);

  localparam int IW =
    (LOOP_COUNT > 1) ? $clog2(LOOP_COUNT) : 1;
  localparam int SW =
    (NUM_SECRETS > 1) ? $clog2(NUM_SECRETS) : 1;
  localparam logic [IW-1:0] LAST  = IW'(LOOP_COUNT - 1);
  localparam logic [SW-1:0] SLAST = SW'(NUM_SECRETS - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOAD   = 3'd1,
    S_BRANCH = 3'd2,
    S_PUB    = 3'd3,
    S_SEC    = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6,
    S_BAD    = 3'd7
  } step_t;

  step_t            step_q, step_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [SW-1:0]    sidx_q, sidx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] pub_d, sec_d;
  logic [WIDTH-1:0] word;
  logic             cond;

  // sidx tracks iter mod NUM_SECRETS without a divider
  always_comb begin
    word = secret_in[int'(sidx_q)*WIDTH +: WIDTH];
  end

  always_comb begin
    cond = 1'b0;
    if (BRANCH_MODE == 1)
      cond = 1'b1;
    else if (BRANCH_MODE == 2)
      cond = |y_q;
  end

  always_comb begin
    step_d = step_q;
    iter_d = iter_q;
    sidx_d = sidx_q;
    x_d    = x_q;
    y_d    = y_q;
    pub_d  = public_out;
    sec_d  = secret_out;
    if (!stutter_in) begin
      unique case (step_q)
        S_INIT: begin
          iter_d = '0;
          sidx_d = '0;
          step_d = S_LOAD;
        end
        S_LOAD: begin
          x_d    = word;
          y_d    = public_in;
          step_d = S_BRANCH;
        end
        S_BRANCH: begin
          step_d = cond ? S_PUB : S_SEC;
        end
        S_PUB: begin
          pub_d  = x_q;
          step_d = S_NEXT;
        end
        S_SEC: begin
          sec_d  = x_q;
          pub_d  = y_q;
          step_d = S_NEXT;
        end
        S_NEXT: begin
          if (iter_q == LAST) begin
            step_d = S_DONE;
          end else begin
            iter_d = iter_q + IW'(1);
            sidx_d = (sidx_q == SLAST) ?
                     '0 : sidx_q + SW'(1);
            step_d = S_LOAD;
          end
        end
        S_DONE: begin
          step_d = S_DONE;
        end
        default: begin
          step_d = S_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= S_INIT;
      iter_q     <= '0;
      sidx_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      public_out <= '0;
      secret_out <= '0;
      stutter    <= 1'b0;
    end else begin
      step_q     <= step_d;
      iter_q     <= iter_d;
      sidx_q     <= sidx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      public_out <= pub_d;
      secret_out <= sec_d;
      stutter    <= stutter_in;
    end
  end

  assign pc   = step_q;
  assign done = (step_q == S_DONE);

endmodule

// File: tb/tb_param_codeblock.sv
// Bench for param_codeblock: vector table, directed corners,
// and a randomized run against an edge-count reference model.
module tb_param_codeblock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst4_n;
  logic st0, st1, st2, st3, st4;
  logic [3:0] pub0, pub1, pub2, pub3;
  logic [7:0] sec2w = {4'hB, 4'h5};
  logic [3:0] sec1w = 4'h5;
  logic [4:0] pub4;
  logic [14:0] sec4;

  logic [3:0] po0, so0, po1, so1, po2, so2, po3, so3;
  logic [4:0] po4, so4;
  logic [2:0] pc0, pc1, pc2, pc3, pc4;
  logic dn0, dn1, dn2, dn3, dn4;
  logic sq0, sq1, sq2, sq3, sq4;

  param_codeblock u0 (
    .clk(clk), .rst_n(rst_n), .stutter_in(st0),
    .secret_in(sec2w), .public_in(pub0),
    .public_out(po0), .secret_out(so0),
    .stutter(sq0), .pc(pc0), .done(dn0));

  param_codeblock #(.BRANCH_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .stutter_in(st1),
    .secret_in(sec2w), .public_in(pub1),
    .public_out(po1), .secret_out(so1),
    .stutter(sq1), .pc(pc1), .done(dn1));

  param_codeblock #(.BRANCH_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .stutter_in(st2),
    .secret_in(sec2w), .public_in(pub2),
    .public_out(po2), .secret_out(so2),
    .stutter(sq2), .pc(pc2), .done(dn2));

  param_codeblock #(.LOOP_COUNT(1), .NUM_SECRETS(1)) u3 (
    .clk(clk), .rst_n(rst_n), .stutter_in(st3),
    .secret_in(sec1w), .public_in(pub3),
    .public_out(po3), .secret_out(so3),
    .stutter(sq3), .pc(pc3), .done(dn3));

  param_codeblock #(
    .WIDTH(5), .NUM_SECRETS(3),
    .LOOP_COUNT(5), .BRANCH_MODE(2)
  ) u4 (
    .clk(clk), .rst_n(rst4_n), .stutter_in(st4),
    .secret_in(sec4), .public_in(pub4),
    .public_out(po4), .secret_out(so4),
    .stutter(sq4), .pc(pc4), .done(dn4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st_in;
    logic [3:0] pub_in;
    logic [2:0] pc;
    logic [3:0] pub;
    logic [3:0] sec;
    logic       done;
  } vec_t;

  vec_t tbl[13];

  task automatic do_reset();
    rst_n = 1'b0;
    st0 = 0; st1 = 0; st2 = 0; st3 = 0;
    pub0 = 4'h3; pub1 = 4'h3;
    pub2 = 4'h0; pub3 = 4'h3;
    tick();
    rst_n = 1'b1;
  endtask

  // reference model for u4, indexed by unstuttered edges
  localparam int L4 = 5;
  int n;
  logic [4:0] xm, ym, pm, sm;
  logic sqm;

  function automatic logic [2:0] exp_pc();
    if (n == 0) return 3'd0;
    if (n >= 1 + 4 * L4) return 3'd6;
    case ((n - 1) % 4)
      0: return 3'd1;
      1: return 3'd2;
      2: return (ym != 0) ? 3'd3 : 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  task automatic model_reset();
    n = 0; xm = 0; ym = 0; pm = 0; sm = 0; sqm = 0;
  endtask

  task automatic model_edge();
    int i;
    sqm = st4;
    if (!st4 && n < 1 + 4 * L4) begin
      n++;
      if (n >= 2 && (n - 2) % 4 == 0) begin
        i  = (n - 2) / 4;
        xm = sec4[(i % 3) * 5 +: 5];
        ym = pub4;
      end
      if (n >= 4 && n % 4 == 0) begin
        if (ym != 0) begin
          pm = xm;
        end else begin
          sm = xm;
          pm = ym;
        end
      end
    end
  endtask

  initial begin
    // mode 1 trace: PUB every iteration, words 5,B,5
    for (int e = 0; e < 13; e++) begin
      tbl[e].st_in  = 1'b0;
      tbl[e].pub_in = 4'h3;
      tbl[e].sec    = 4'h0;
      tbl[e].done   = 1'b0;
      tbl[e].pub    = (e < 3) ? 4'h0 :
                      (e < 7) ? 4'h5 :
                      (e < 11) ? 4'hB : 4'h5;
      case (e % 4)
        0: tbl[e].pc = 3'd1;
        1: tbl[e].pc = 3'd2;
        2: tbl[e].pc = 3'd3;
        default: tbl[e].pc = 3'd5;
      endcase
    end
    tbl[12].pc   = 3'd6;
    tbl[12].done = 1'b1;

    rst4_n = 1'b0;
    st4 = 0; pub4 = 0; sec4 = 0;
    rst_n = 1'b0;
    st0 = 0; st1 = 0; st2 = 0; st3 = 0;
    pub0 = 4'h3; pub1 = 4'h3;
    pub2 = 4'h0; pub3 = 4'h3;
    #2;
    chk("rst_pc", pc0, 3'd0);
    chk("rst_pub", po0, 4'h0);
    chk("rst_sec", so0, 4'h0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_stut", sq0, 1'b0);
    tick();
    rst_n = 1'b1;

    // concurrent run of modes 0/1/2 and the single-loop instance
    for (int e = 1; e <= 13; e++) begin
      st1  = tbl[e-1].st_in;
      pub1 = tbl[e-1].pub_in;
      tick();
      chk($sformatf("m1_pc_e%0d", e), pc1, tbl[e-1].pc);
      chk($sformatf("m1_pub_e%0d", e), po1, tbl[e-1].pub);
      chk($sformatf("m1_sec_e%0d", e), so1, tbl[e-1].sec);
      chk($sformatf("m1_done_e%0d", e), dn1, tbl[e-1].done);
      if (e >= 4)
        chk($sformatf("m0_pub_e%0d", e), po0, 4'h3);
      if (e == 4 || e == 8 || e == 12)
        chk($sformatf("m0_sec_e%0d", e), so0,
            (e == 8) ? 4'hB : 4'h5);
      if (e == 12) chk("m0_done12", dn0, 1'b0);
      if (e == 13) chk("m0_done13", dn0, 1'b1);
      if (e == 2) pub2 = 4'h7;
      if (e == 4) begin
        chk("m2_sec_it0", so2, 4'h5);
        chk("m2_pub_it0", po2, 4'h0);
      end
      if (e == 8) begin
        chk("m2_pub_it1", po2, 4'hB);
        chk("m2_sec_it1", so2, 4'h5);
      end
      if (e == 4) begin
        chk("l1_pc4", pc3, 3'd5);
        chk("l1_sec4", so3, 4'h5);
        chk("l1_pub4", po3, 4'h3);
        chk("l1_done4", dn3, 1'b0);
      end
      if (e == 5) begin
        chk("l1_done5", dn3, 1'b1);
        st3 = 1'b1;
      end
      if (e >= 6 && e <= 8) begin
        chk($sformatf("l1_dstut_done_e%0d", e), dn3, 1'b1);
        chk($sformatf("l1_dstut_sq_e%0d", e), sq3, 1'b1);
        chk($sformatf("l1_dstut_pub_e%0d", e), po3, 4'h3);
        chk($sformatf("l1_dstut_sec_e%0d", e), so3, 4'h5);
      end
    end

    // stutter held for three edges while in BRANCH
    do_reset();
    tick();
    tick();
    chk("stb_pc_pre", pc0, 3'd2);
    st0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stb_pc_%0d", k), pc0, 3'd2);
      chk($sformatf("stb_sq_%0d", k), sq0, 1'b1);
      chk($sformatf("stb_pub_%0d", k), po0, 4'h0);
      chk($sformatf("stb_sec_%0d", k), so0, 4'h0);
    end
    st0 = 1'b0;
    tick();
    chk("stb_sq_after", sq0, 1'b0);
    chk("stb_pc_after", pc0, 3'd4);
    for (int e = 7; e <= 15; e++) tick();
    chk("stb_done15", dn0, 1'b0);
    tick();
    chk("stb_done16", dn0, 1'b1);

    // asynchronous reset pulse while in PUB
    do_reset();
    for (int e = 1; e <= 7; e++) tick();
    chk("arst_pc_pre", pc1, 3'd3);
    chk("arst_pub_pre", po1, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc1, 3'd0);
    chk("arst_pub", po1, 4'h0);
    chk("arst_sec", so1, 4'h0);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk($sformatf("rep_pc_e%0d", e), pc1, tbl[e-1].pc);
      chk($sformatf("rep_pub_e%0d", e), po1, tbl[e-1].pub);
      chk($sformatf("rep_done_e%0d", e), dn1, tbl[e-1].done);
    end

    // randomized run of a wider mode-2 configuration
    model_reset();
    rst4_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst4_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_rst_pc", pc4, 3'd0);
        chk("rnd_rst_pub", po4, 5'd0);
        chk("rnd_rst_sec", so4, 5'd0);
        chk("rnd_rst_sq", sq4, 1'b0);
        rst4_n = 1'b1;
      end
      st4  = ($urandom_range(0, 3) == 0);
      pub4 = ($urandom_range(0, 2) == 0) ?
             5'd0 : 5'($urandom);
      sec4 = 15'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_pc", pc4, exp_pc());
      chk("rnd_done", dn4, exp_pc() == 3'd6);
      chk("rnd_pub", po4, pm);
      chk("rnd_sec", so4, sm);
      chk("rnd_sq", sq4, sqm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_codeblock.md
PARAM_CODEBLOCK -- requirements
Module: param_codeblock

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of secret, public and output data words (>=1).
REQ-002 SHALL have parameter NUM_SECRETS, default 2: number of secret input words (>=1).
REQ-003 SHALL have parameter LOOP_COUNT, default 3: number of load/branch/write iterations (>=1).
REQ-004 SHALL have parameter BRANCH_MODE, default 0: 0 = constant-false branch (dead public branch), 1 = constant-true branch, 2 = data-dependent branch (public word nonzero).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port stutter_in  input  1  1 = hold program state this cycle.
REQ-008 SHALL have port secret_in  input  NUM_SECRETS*WIDTH  packed secret words; word k = bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port public_in  input  WIDTH  public data word.
REQ-010 SHALL have port public_out  output reg  WIDTH  public (observable) result.
REQ-011 SHALL have port secret_out  output reg  WIDTH  secret result.
REQ-012 SHALL have port stutter  output reg  1  registered copy of stutter_in.
REQ-013 SHALL have port pc  output  3  current program step encoding.
REQ-014 SHALL have port done  output  1  high exactly when pc = DONE.

Function
REQ-015 SHALL implement steps INIT=0, LOAD=1, BRANCH=2, PUB=3, SEC=4, NEXT=5, DONE=6; encoding 7 unused, SHALL go to DONE if ever reached.
REQ-016 stutter SHALL be loaded with stutter_in every rising edge, independent of pc.
REQ-017 When stutter_in=1 at an edge, pc, iteration counter, x, y, public_out and secret_out SHALL hold.
REQ-018 When stutter_in=0, exactly one step transition SHALL occur per edge as follows.
REQ-019 INIT: iter <= 0; -> LOAD.
REQ-020 LOAD: x <= secret word (iter mod NUM_SECRETS); y <= public_in; -> BRANCH.
REQ-021 BRANCH: cond = 0 (mode 0), 1 (mode 1), (y != 0) (mode 2); cond -> PUB else -> SEC; no output change.
REQ-022 PUB: public_out <= x; -> NEXT.
REQ-023 SEC: secret_out <= x; public_out <= y; -> NEXT.
REQ-024 NEXT: if iter == LOOP_COUNT-1 -> DONE, else iter <= iter+1 and -> LOAD.
REQ-025 DONE: all registers hold; terminal until reset.
REQ-026 iter SHALL be max(1,$clog2(LOOP_COUNT)) bits; secret index SHALL wrap to 0 after NUM_SECRETS-1; NUM_SECRETS=1 always selects word 0.
REQ-027 LOOP_COUNT=1 SHALL go NEXT -> DONE after the first iteration.
REQ-028 Latency from reset release with no stutter: first output write at edge 4 (INIT, LOAD, BRANCH, PUB/SEC); DONE reached after 1 + 4*LOOP_COUNT unstuttered edges.
REQ-029 done and pc SHALL be combinational decodes of the step register only.

Reset
REQ-030 rst_n=0 SHALL immediately force pc=INIT, iter=0, x=0, y=0, public_out=0, secret_out=0, stutter=0, regardless of clk.
REQ-031 Reset asserted mid-iteration SHALL discard all progress; after release execution restarts at INIT.
REQ-032 Reset SHALL take priority over stutter_in at every edge.

Verification
REQ-033 Defaults, mode 0, secret_in={4'hB,4'h5}, public_in=4'h3, no stutter: secret_out 5 then B then 5; public_out 3 throughout after edge 4; public_out never equals a secret word unless equal to 3; done after 13 edges.
REQ-034 Mode 1, same stimulus: public_out sequence 5, B, 5; secret_out stays 0; done after 13 edges.
REQ-035 Mode 2, public_in=0 in iteration 0 and 4'h7 in iteration 1: iteration 0 takes SEC (secret_out=5, public_out=0), iteration 1 takes PUB (public_out=B).
REQ-036 stutter_in=1 for 3 cycles while pc=BRANCH: pc, outputs unchanged for 3 edges, stutter output 1 one edge after each stutter_in; total time to done extends by exactly 3 edges.
REQ-037 rst_n pulsed low between edges while pc=PUB: outputs and pc go to 0 immediately, before next edge; after release sequence repeats from INIT identically.
REQ-038 LOOP_COUNT=1, NUM_SECRETS=1: done after 5 edges; stutter in DONE keeps done=1 and outputs constant.
